// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// between EX/MEM and MEM. Misses refill a whole line in beat order over a
// single-outstanding bus; stores always write through. Lookup is combinational
// on the held request address.
// Optional build macro DCACHE_PERF_EN adds saturating load hit/miss counters
// (perf_hit_o / perf_miss_o).
module dcache_ctrl #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_rw_i,
  input  logic [1:0]  req_width_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        fc_stall_i,
  output logic        dcache_ready_o,
  output logic [31:0] dcache_data_o,
  output logic        dcache_stall_req_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] perf_hit_o,
  output logic [31:0] perf_miss_o
`endif
);

  localparam int IDX_W   = $clog2(LINES);
  localparam int OFF_W   = $clog2(WORDS);
  localparam int LSB_IDX = OFF_W + 2;
  localparam int TAG_W   = 32 - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_t;

  state_t                            state_q, state_d;
  logic [OFF_W-1:0]                  beat_q;
  logic [LINES-1:0][TAG_W-1:0]       tag_q;
  logic [LINES-1:0]                  valid_q;
  logic [LINES-1:0][WORDS-1:0][31:0] data_q;
  logic                              served_q;
  // Request captured at acceptance so the bus stays stable even if
  // req_valid_i drops while the transaction is in flight.
  logic [31:0]                       addr_q, wdata_q;
  logic [1:0]                        width_q;
  logic                              load_q;     // RESP returns line data
  logic                              resp_en_q;  // cleared if the request vanishes

  // ---- live request decode ----
  logic [31:0]      req_addr_al;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [OFF_W-1:0] req_woff;
  logic             req_hit, req_take, req_load;

  // Force natural alignment; misaligned addresses are silently rounded down
  always_comb begin
    req_addr_al = req_addr_i;
    if (req_width_i == 2'b10)      req_addr_al[0]   = 1'b0;
    else if (req_width_i == 2'b11) req_addr_al[1:0] = 2'b00;
  end

  assign req_idx  = req_addr_al[LSB_IDX +: IDX_W];
  assign req_tag  = req_addr_al[31 -: TAG_W];
  assign req_woff = req_addr_al[2 +: OFF_W];
  assign req_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  // While served_q is set the held request was already answered; MEM keeps it.
  assign req_take = (state_q == S_IDLE) && !served_q && req_valid_i;
  assign req_load = !req_rw_i && (req_width_i != 2'b00);

  // ---- latched request decode ----
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic [OFF_W-1:0] l_woff;
  logic             l_hit;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;

  assign l_idx  = addr_q[LSB_IDX +: IDX_W];
  assign l_tag  = addr_q[31 -: TAG_W];
  assign l_woff = addr_q[2 +: OFF_W];
  assign l_hit  = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  // Store byte enables and lane replication of right-aligned store data
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = wdata_q;
    case (width_q)
      2'b01: begin be_c = 4'b0001 << addr_q[1:0]; wdata_c = {4{wdata_q[7:0]}};  end
      2'b10: begin be_c = 4'b0011 << addr_q[1:0]; wdata_c = {2{wdata_q[15:0]}}; end
      2'b11: begin be_c = 4'b1111;                wdata_c = wdata_q;            end
      default: ;
    endcase
  end

  // ---- FSM next state and outputs ----
  logic        ready_c, stall_c, bus_req_c, bus_we_c;
  logic [31:0] data_c, bus_addr_c, bus_wdata_c;
  logic [3:0]  bus_be_c;

  // Next state, lookup response, stall request and bus drive
  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    stall_c     = 1'b0;
    data_c      = 32'd0;
    bus_req_c   = 1'b0;
    bus_we_c    = 1'b0;
    bus_addr_c  = 32'd0;
    bus_wdata_c = 32'd0;
    bus_be_c    = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (req_take) begin
          if (req_load) begin
            if (req_hit) begin
              ready_c = 1'b1;
              data_c  = data_q[req_idx][req_woff] >> {req_addr_al[1:0], 3'b000};
            end else begin
              stall_c = 1'b1;
              state_d = S_REFILL;
            end
          end else begin
            // Stores write through; a width-00 no-op skips the bus and
            // answers with a zero RESP on the following cycle.
            stall_c = 1'b1;
            state_d = (req_width_i == 2'b00) ? S_RESP : S_WRITE;
          end
        end
      end
      S_REFILL: begin
        stall_c    = 1'b1;
        bus_req_c  = 1'b1;
        bus_addr_c = {addr_q[31:LSB_IDX], beat_q, 2'b00};
        if (bus_ack_i && (beat_q == OFF_W'(WORDS - 1))) state_d = S_RESP;
      end
      S_WRITE: begin
        stall_c     = 1'b1;
        bus_req_c   = 1'b1;
        bus_we_c    = 1'b1;
        bus_addr_c  = {addr_q[31:2], 2'b00};
        bus_be_c    = be_c;
        bus_wdata_c = wdata_c;
        if (bus_ack_i) state_d = S_RESP;
      end
      S_RESP: begin
        ready_c = resp_en_q && req_valid_i;
        data_c  = load_q ? (data_q[l_idx][l_woff] >> {addr_q[1:0], 3'b000}) : 32'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lookup-derived outputs can see a valid request during reset; hold them low.
  assign dcache_ready_o     = ready_c & ~rst;
  assign dcache_stall_req_o = stall_c & ~rst;
  assign dcache_data_o      = rst ? 32'd0 : data_c;
  assign bus_req_o          = bus_req_c;
  assign bus_we_o           = bus_we_c;
  assign bus_addr_o         = bus_addr_c;
  assign bus_wdata_o        = bus_wdata_c;
  assign bus_be_o           = bus_be_c;

  // State, tags/valids, captured request and served flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      tag_q     <= '0;
      valid_q   <= '0;
      served_q  <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      width_q   <= 2'b00;
      load_q    <= 1'b0;
      resp_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      served_q <= fc_stall_i & (served_q | ready_c);
      if (req_take && (state_d != S_IDLE)) begin
        addr_q    <= req_addr_al;
        wdata_q   <= req_wdata_i;
        width_q   <= req_width_i;
        load_q    <= req_load;
        resp_en_q <= 1'b1;
        beat_q    <= '0;
        // The victim line is dropped up front so a partially refilled line
        // can never look valid.
        if (req_load) valid_q[req_idx] <= 1'b0;
      end
      if ((state_q == S_REFILL || state_q == S_WRITE) && !req_valid_i)
        resp_en_q <= 1'b0;
      if (state_q == S_REFILL && bus_ack_i) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == OFF_W'(WORDS - 1)) begin
          valid_q[l_idx] <= 1'b1;
          tag_q[l_idx]   <= l_tag;
        end
      end
    end
  end

  // Line data: refill beats, and byte merges for store hits
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && bus_ack_i)
      data_q[l_idx][beat_q] <= bus_rdata_i;
    else if (state_q == S_WRITE && bus_ack_i && l_hit)
      for (int b = 0; b < 4; b++)
        if (be_c[b]) data_q[l_idx][l_woff][8*b +: 8] <= wdata_c[8*b +: 8];
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hit_q, perf_miss_q;

  // Saturating counters of accepted loads, split by lookup outcome
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_q  <= 32'd0;
      perf_miss_q <= 32'd0;
    end else if (req_take && req_load) begin
      if (req_hit) begin
        if (perf_hit_q != 32'hFFFF_FFFF) perf_hit_q <= perf_hit_q + 32'd1;
      end else begin
        if (perf_miss_q != 32'hFFFF_FFFF) perf_miss_q <= perf_miss_q + 32'd1;
      end
    end
  end

  assign perf_hit_o  = perf_hit_q;
  assign perf_miss_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl. The reference model is a flat word
// memory plus a per-index record of which tag the cache should hold; load
// data is always the memory word (write-through keeps them equal), and the
// tag record decides whether a refill must appear on the bus.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_rw_i, fc_stall_i;
  logic [1:0]  req_width_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        dcache_ready_o, dcache_stall_req_o;
  logic [31:0] dcache_data_o;
  logic        bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;
`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hit_o, perf_miss_o;
`endif

  dcache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_rw_i(req_rw_i), .req_width_i(req_width_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .fc_stall_i(fc_stall_i),
    .dcache_ready_o(dcache_ready_o), .dcache_data_o(dcache_data_o),
    .dcache_stall_req_o(dcache_stall_req_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
`ifdef DCACHE_PERF_EN
    , .perf_hit_o(perf_hit_o), .perf_miss_o(perf_miss_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] mem [logic [31:0]];
  bit          cv [16];
  logic [23:0] ct [16];
  int          checks = 0, errors = 0, n_acks = 0;
  int          ph = 0, pm = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every ready pulse must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && dcache_ready_o) begin
      if (resp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got ready with data %h, expected no response", dcache_data_o);
      end else begin
        check("resp_data", dcache_data_o, resp_q.pop_front());
      end
    end
  end

  // Bus monitor: every acked beat must match the oldest expected transaction
  always @(negedge clk) begin
    bus_t e;
    if (!rst && bus_req_o && bus_ack_i) begin
      n_acks++;
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: got we=%0b addr=%h, expected no transaction", bus_we_o, bus_addr_o);
      end else begin
        e = bus_q.pop_front();
        check("bus_we", {31'd0, bus_we_o}, {31'd0, e.we});
        check("bus_addr", bus_addr_o, e.addr);
        if (e.we) begin
          check("bus_be", {28'd0, bus_be_o}, {28'd0, e.be});
          check("bus_wdata", bus_wdata_o, e.wdata);
        end
      end
    end
  end

  // Bus slave: random 0..2 cycle ack latency, read data from the model memory
  initial begin
    int waitc;
    waitc = 0;
    bus_ack_i = 1'b0;
    bus_rdata_i = 32'd0;
    forever begin
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      if (rst) waitc = 0;
      else if (bus_req_o) begin
        if (waitc == 0) begin
          bus_ack_i   = 1'b1;
          bus_rdata_i = bus_we_o ? 32'd0 : mem_rd(bus_addr_o);
          waitc = $urandom_range(0, 2);
        end else waitc--;
      end
    end
  end

  function automatic logic [31:0] align(input logic [31:0] a, input logic [1:0] w);
    logic [31:0] r;
    r = a;
    if (w == 2'd2) r[0] = 1'b0;
    else if (w == 2'd3) r[1:0] = 2'b00;
    return r;
  endfunction

  task automatic push_refill(input logic [31:0] al);
    bus_t e;
    for (int b = 0; b < 4; b++) begin
      e.we = 1'b0; e.addr = {al[31:4], 4'h0} + 32'(4 * b); e.be = 4'h0; e.wdata = 32'd0;
      bus_q.push_back(e);
    end
    cv[al[7:4]] = 1'b1;
    ct[al[7:4]] = al[31:8];
  endtask

  // Issue one request, predict its outcome, wait for ready, optionally hold
  // the pipeline frozen for hold cycles to exercise the served flag.
  task automatic do_req(input logic rw, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d, input int hold);
    logic [31:0] al, exp, rep, word;
    logic [3:0]  be;
    bit          hit, exp_stall, seen;
    int          lat;
    bus_t        e;
    al  = align(a, w);
    hit = 1'b0;
    exp = 32'd0;
    exp_stall = 1'b1;
    if (w != 2'd0 && !rw) begin
      hit = cv[al[7:4]] && (ct[al[7:4]] == al[31:8]);
      exp_stall = !hit;
      if (hit) ph++; else begin pm++; push_refill(al); end
      exp = mem_rd(al) >> (8 * al[1:0]);
    end else if (w != 2'd0) begin
      case (w)
        2'd1:    begin be = 4'b0001 << al[1:0]; rep = {4{d[7:0]}};  end
        2'd2:    begin be = 4'b0011 << al[1:0]; rep = {2{d[15:0]}}; end
        default: begin be = 4'b1111;            rep = d;            end
      endcase
      e.we = 1'b1; e.addr = {al[31:2], 2'b00}; e.be = be; e.wdata = rep;
      bus_q.push_back(e);
      word = mem_rd(al);
      for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = rep[8*b +: 8];
      mem[{al[31:2], 2'b00}] = word;
    end
    resp_q.push_back(exp);
    req_valid_i = 1'b1; req_rw_i = rw; req_width_i = w; req_addr_i = a; req_wdata_i = d;
    fc_stall_i = (hold > 0);
    lat = 0; seen = 1'b0;
    while (lat < 300 && !seen) begin
      @(negedge clk);
      if (lat == 0) check("stall_req", {31'd0, dcache_stall_req_o}, {31'd0, exp_stall});
      if (dcache_ready_o) seen = 1'b1; else lat++;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got no ready in 300 cycles, expected one (addr %h)", a);
    end else if (w == 2'd0)  check("noop_latency", lat, 1);
    else if (rw)             check("store_latency_ge2", {31'd0, lat >= 2}, 32'd1);
    else if (hit)            check("hit_latency", lat, 0);
    else                     check("miss_latency_ge5", {31'd0, lat >= 5}, 32'd1);
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        check("served_ready", {31'd0, dcache_ready_o}, 32'd0);
        check("served_bus", {31'd0, bus_req_o}, 32'd0);
      end
      @(posedge clk); #1;
      fc_stall_i = 1'b0;
      @(negedge clk);
      check("served_release", {31'd0, dcache_ready_o}, 32'd0);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [23:0] tg;
    logic [7:0]  lo;
    int n0, k;
    rst = 1'b1;
    req_valid_i = 1'b0; req_rw_i = 1'b0; req_width_i = 2'd0;
    req_addr_i = 32'd0; req_wdata_i = 32'd0; fc_stall_i = 1'b0;
    for (int i = 0; i < 16; i++) begin cv[i] = 1'b0; ct[i] = 24'd0; end
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;

    @(negedge clk);
    check("rst_ready", {31'd0, dcache_ready_o}, 32'd0);
    check("rst_stall", {31'd0, dcache_stall_req_o}, 32'd0);
    check("rst_data", dcache_data_o, 32'd0);
    check("rst_bus", {bus_req_o, bus_we_o, bus_be_o, 26'd0}, 32'd0);
    check("rst_bus_addr", bus_addr_o, 32'd0);
    check("rst_bus_wdata", bus_wdata_o, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed walk through the basic load/store flows
    do_req(1'b0, 2'd3, 32'h100, 32'd0, 0);          // cold miss -> 0x11
    do_req(1'b0, 2'd1, 32'h106, 32'd0, 0);          // hit, byte 2 of 0x22 -> 0
    do_req(1'b1, 2'd3, 32'h104, 32'h0000_AB00, 0);  // store word, line hit
    do_req(1'b0, 2'd1, 32'h105, 32'd0, 0);          // -> 0xAB
    do_req(1'b1, 2'd2, 32'h10A, 32'h0000_BEEF, 0);  // be 1100 @0x108
    do_req(1'b0, 2'd3, 32'h108, 32'd0, 0);          // -> 0xBEEF0033
    do_req(1'b0, 2'd3, 32'h100, 32'd0, 3);          // hit under 3-cycle freeze
    do_req(1'b0, 2'd3, 32'h10C, 32'd0, 0);          // normal after release
    do_req(1'b0, 2'd0, 32'h100, 32'd0, 0);          // width-00 no-op
    do_req(1'b1, 2'd1, 32'h3F3, 32'h0000_00C5, 0);  // store miss: no allocate
    do_req(1'b0, 2'd1, 32'h3F3, 32'd0, 0);          // must miss and see 0xC5

    // Reset during beat 2 of a refill at 0x200
    push_refill(32'h200);
    pm++;
    resp_q.push_back(mem_rd(32'h200));
    n0 = n_acks;
    req_valid_i = 1'b1; req_rw_i = 1'b0; req_width_i = 2'd3; req_addr_i = 32'h200;
    k = 0;
    while (n_acks < n0 + 2 && k < 100) begin @(negedge clk); #1; k++; end
    check("rst_test_beats_seen", {31'd0, n_acks >= n0 + 2}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_bus_req", {31'd0, bus_req_o}, 32'd0);
    check("midrst_bus_addr", bus_addr_o, 32'd0);
    check("midrst_stall", {31'd0, dcache_stall_req_o}, 32'd0);
    check("midrst_ready", {31'd0, dcache_ready_o}, 32'd0);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    bus_q.delete(); resp_q.delete();
    for (int i = 0; i < 16; i++) cv[i] = 1'b0;
    ph = 0; pm = 0;
    @(posedge clk); #1 rst = 1'b0;
    do_req(1'b0, 2'd3, 32'h200, 32'd0, 0);          // full refetch after reset

    // req_valid drops mid-refill: line still fills, no response pulse
    push_refill(32'h300);
    pm++;
    n0 = n_acks;
    req_valid_i = 1'b1; req_rw_i = 1'b0; req_width_i = 2'd3; req_addr_i = 32'h300;
    k = 0;
    while (n_acks < n0 + 1 && k < 100) begin @(negedge clk); #1; k++; end
    @(posedge clk); #1 req_valid_i = 1'b0;
    k = 0;
    while (bus_q.size() != 0 && k < 100) begin @(negedge clk); #1; k++; end
    check("drop_refill_done", bus_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    do_req(1'b0, 2'd3, 32'h304, 32'd0, 0);          // hit in the dropped-request line

    // Randomized traffic over a few conflicting tags
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: tg = 24'h1; 1: tg = 24'h2; 2: tg = 24'h3; default: tg = 24'h41;
      endcase
      lo = 8'($urandom);
      do_req(($urandom_range(0, 9) < 3), (($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3))),
             {tg, lo}, $urandom, (($urandom_range(0, 9) < 2) ? int'($urandom_range(2, 3)) : 0));
    end

    repeat (5) @(posedge clk);
    check("bus_q_drained", bus_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
`ifdef DCACHE_PERF_EN
    check("perf_hit", perf_hit_o, ph);
    check("perf_miss", perf_miss_o, pm);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
